// File: rtl/ir_key_led_ctrl.sv
// ir_key_led_ctrl: checks NEC IR frames, decodes the key byte and drives a registered 18-bit LED bank.
// Define IR_ADDR_CHECK_EN to also require frame[15:0] == ADDR_CODE.
module ir_key_led_ctrl #(
    parameter int          HOLDOFF_CYC = 5_000_000,
    parameter logic [15:0] ADDR_CODE   = 16'h00FF,
    parameter logic [7:0]  KEY_SHIFT1  = 8'h1E,
    parameter logic [7:0]  KEY_SHIFT0  = 8'h1B,
    parameter logic [7:0]  KEY_INVERT  = 8'h1F,
    parameter logic [7:0]  KEY_MUTE    = 8'h0C
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    output logic [17:0] oLEDR,
    output logic [7:0]  oKEY,
    output logic        oKEY_VALID,
    output logic        oERR,
    output logic        oMUTED
);
    typedef enum logic [1:0] {IDLE, CHECK, APPLY, HOLDOFF} state_t;
    localparam int LAST = HOLDOFF_CYC > 0 ? HOLDOFF_CYC - 1 : 0;
    localparam int CW   = LAST > 0 ? $clog2(LAST + 1) : 1;
    state_t        state_q;
    logic          rdy_q, ph_q, frame_ok;
    logic [31:0]   frame_q;
    logic [CW-1:0] cnt_q;
    logic [17:0]   saved_q, led_d;
    logic [7:0]    key;
    assign key = frame_q[23:16];
`ifdef IR_ADDR_CHECK_EN
    assign frame_ok = frame_q[31:24] == ~key && frame_q[15:0] == ADDR_CODE;
`else
    assign frame_ok = frame_q[31:24] == ~key;
    logic unused_addr;
    assign unused_addr = ^{frame_q[15:0], ADDR_CODE};
`endif
    // Non-mute keys are frozen out while muted; mute itself is handled in APPLY.
    always_comb
        led_d = oMUTED ? oLEDR :
                key == KEY_SHIFT1 ? {oLEDR[16:0], 1'b1} :
                key == KEY_SHIFT0 ? {oLEDR[16:0], 1'b0} :
                key == KEY_INVERT ? ~oLEDR : oLEDR;
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b0;
            ph_q       <= 1'b0;
            frame_q    <= '0;
            cnt_q      <= '0;
            saved_q    <= '0;
            oLEDR      <= '0;
            oKEY       <= '0;
            oKEY_VALID <= 1'b0;
            oERR       <= 1'b0;
            oMUTED     <= 1'b0;
        end else begin
            rdy_q      <= iDATA_READY;
            oKEY_VALID <= 1'b0;
            oERR       <= 1'b0;
            case (state_q)
                IDLE: if (iDATA_READY && !rdy_q) begin
                    frame_q <= iDATA;
                    state_q <= CHECK;
                end
                // Two cycles in CHECK place oERR two edges after the latch.
                CHECK: begin
                    ph_q <= !ph_q;
                    if (ph_q) begin
                        state_q <= frame_ok ? APPLY : IDLE;
                        oERR    <= !frame_ok;
                    end
                end
                APPLY: begin
                    oKEY       <= key;
                    oKEY_VALID <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= HOLDOFF;
                    if (key == KEY_MUTE) begin
                        if (!oMUTED) saved_q <= oLEDR;
                        oLEDR  <= oMUTED ? saved_q : '0;
                        oMUTED <= !oMUTED;
                    end else
                        oLEDR <= led_d;
                end
                HOLDOFF: if (cnt_q >= CW'(LAST)) state_q <= IDLE;
                         else cnt_q <= cnt_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ir_key_led_ctrl.sv
// tb_ir_key_led_ctrl: scoreboard bench for ir_key_led_ctrl with HOLDOFF_CYC=16.
module tb_ir_key_led_ctrl;
    logic        clk = 1'b0, rst = 1'b0, rdy = 1'b0;
    logic [31:0] data = '0;
    logic [17:0] oLEDR;
    logic [7:0]  oKEY;
    logic        oKEY_VALID, oERR, oMUTED;
    int total = 0, bad = 0, cyc = 0, nvalid = 0, n0;
    typedef struct {int cyc; bit err; logic [7:0] key; logic [17:0] led; bit muted;} exp_t;
    exp_t q[$];
    exp_t e;
    logic [17:0] led_m = '0, saved_m = '0;
    logic [7:0]  key_m = '0;
    bit          muted_m = 1'b0;
    localparam int DROP = 0, OK = 1, ERR = 2;

    ir_key_led_ctrl #(.HOLDOFF_CYC(16)) dut (
        .iCLK(clk), .iRST(rst), .iDATA_READY(rdy), .iDATA(data),
        .oLEDR(oLEDR), .oKEY(oKEY), .oKEY_VALID(oKEY_VALID), .oERR(oERR), .oMUTED(oMUTED)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] frame(input logic [7:0] k, input logic [15:0] a = 16'h00FF);
        return {~k, k, a};
    endfunction

    task automatic apply(input logic [7:0] k);
        key_m = k;
        if (k == 8'h0C) begin
            if (!muted_m) begin saved_m = led_m; led_m = '0; end
            else led_m = saved_m;
            muted_m = !muted_m;
        end else if (!muted_m) begin
            if (k == 8'h1E) led_m = {led_m[16:0], 1'b1};
            else if (k == 8'h1B) led_m = {led_m[16:0], 1'b0};
            else if (k == 8'h1F) led_m = ~led_m;
        end
    endtask

    // Called on a falling edge; the frame is latched on the next rising edge.
    task automatic send(input logic [31:0] d, input int kind, input int hold, input int gap);
        data = d;
        rdy  = 1'b1;
        if (kind == OK) begin
            apply(d[23:16]);
            q.push_back('{cyc + 4, 1'b0, key_m, led_m, muted_m});
        end else if (kind == ERR)
            q.push_back('{cyc + 3, 1'b1, key_m, led_m, muted_m});
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (i == 0) data = $urandom;
            if (i + 1 == hold) rdy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_led", oLEDR, 0);
        check("rst_key", oKEY, 0);
        check("rst_valid", oKEY_VALID, 0);
        check("rst_err", oERR, 0);
        check("rst_muted", oMUTED, 0);
        led_m = '0; saved_m = '0; key_m = '0; muted_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && (oKEY_VALID || oERR)) begin
            if (q.size() == 0) check("unexpected_pulse", {oERR, oKEY_VALID}, 0);
            else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_err", oERR, e.err);
                check("pulse_valid", oKEY_VALID, !e.err);
                check("pulse_key", oKEY, e.key);
                check("pulse_led", oLEDR, e.led);
                check("pulse_muted", oMUTED, e.muted);
            end
            if (oKEY_VALID) nvalid++;
        end
    end

    initial begin
        #2;
        do_reset();
        repeat (3) send(32'hE11E00FF, OK, 1, 24);
        check("t1_led", oLEDR, 18'h00007);
        check("t1_key", oKEY, 8'h1E);
        check("t1_count", nvalid, 3);
        send(frame(8'h1F), OK, 1, 24);
        check("t2_invert", oLEDR, 18'h3FFF8);
        send(frame(8'h1B), OK, 1, 24);
        check("t2_msb_drop", oLEDR, 18'h3FFF0);
        do_reset();
        send(frame(8'h1E), OK, 1, 24);
        send(frame(8'h1B), OK, 1, 24);
        send(frame(8'h1E), OK, 1, 24);
        check("t3_pre", oLEDR, 18'h00005);
        send(frame(8'h0C), OK, 1, 24);
        check("t3_mute_led", oLEDR, 0);
        check("t3_mute_flag", oMUTED, 1);
        send(frame(8'h1E), OK, 1, 24);
        check("t3_muted_key", oLEDR, 0);
        send(frame(8'h0C), OK, 1, 24);
        check("t3_unmute_led", oLEDR, 18'h00005);
        check("t3_unmute_flag", oMUTED, 0);
        send(frame(8'h55), OK, 1, 24);
        check("t3_unknown", oLEDR, 18'h00005);
        send(32'h121E00FF, ERR, 1, 24);
        check("t4_err_led", oLEDR, 18'h00005);
        send(frame(8'h1B), OK, 1, 5);
        send(frame(8'h1E), DROP, 1, 24);
        check("t4_drop_led", oLEDR, 18'h0000A);
        n0 = nvalid;
        send(frame(8'h1E), OK, 10, 24);
        check("t5_held_once", nvalid - n0, 1);
        check("t5_held_led", oLEDR, 18'h00015);
        send(frame(8'h1F), OK, 1, 8);
        do_reset();
        send(frame(8'h1E), OK, 1, 24);
        check("t5_after_rst", oLEDR, 18'h00001);
`ifdef IR_ADDR_CHECK_EN
        send(32'hE11E10EF, ERR, 1, 24);
        check("t6_addr_bad", oLEDR, 18'h00001);
        send(32'hE11E00FF, OK, 1, 24);
        check("t6_addr_ok", oLEDR, 18'h00003);
`else
        send(32'hE11E10EF, OK, 1, 24);
        check("t6_addr_ignored", oLEDR, 18'h00003);
`endif
        repeat (4) @(negedge clk);
        check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
